pio_cmd_bridge: RTL and testbench

FPGA-side command bridge between the HPS lightweight PIO ports (enable, instruct, mem_sel, flags, data_out) and a coprocessor datapath. It replaces direct PIO-to-datapath wiring with a handshaked, queued, parametrised path. Each rising edge of the HPS enable pushes one instruction into a command FIFO. A dispatch FSM issues queued commands to the coprocessor with valid/ready, then waits for completion with a timeout. Result data and status flags are returned to the HPS PIO inputs.

---
 rtl/pio_cmd_bridge_pkg.sv | 24 ++
 rtl/pio_cmd_bridge_cmd_fifo.sv | 70 +++++++
 rtl/pio_cmd_bridge.sv | 173 +++++++++++++++++
 tb/tb_pio_cmd_bridge.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_cmd_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pio_bridge_pkg
// Description : Shared types and constants for the PIO command bridge:
//               dispatch FSM state encoding and HPS flag bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package pio_bridge_pkg;

  // Dispatch FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // Bit positions inside hps_flags
  localparam int FLG_DONE = 0;
  localparam int FLG_BUSY = 1;
  localparam int FLG_ERR  = 2;
  localparam int FLG_FULL = 3;

endpackage : pio_bridge_pkg
`default_nettype wire

// File: rtl/pio_cmd_bridge_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cmd_fifo
// Description : Synchronous command FIFO. A push into a full FIFO is accepted
//               only when a pop happens in the same cycle. Read data is the
//               head entry, presented combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (count_q == C_DEPTH);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule : cmd_fifo
`default_nettype wire

// File: rtl/pio_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : pio_cmd_bridge
// Description : HPS PIO to coprocessor command bridge. Enable rising edges
//               queue instructions; a dispatch FSM issues them with
//               valid/ready, waits for completion with a timeout, and
//               returns result data plus sticky status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_cmd_bridge #(
  parameter int INSTR_W     = 29,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               hps_enable,
  input  logic [INSTR_W-1:0] hps_instruct,
  input  logic               hps_mem_sel,
  input  logic               hps_clr_err,
  output logic [3:0]         hps_flags,
  output logic [DATA_W-1:0]  hps_data_out,
  output logic               cop_valid,
  input  logic               cop_ready,
  output logic [INSTR_W-1:0] cop_instr,
  output logic               cop_mem_sel,
  input  logic               cop_done,
  input  logic [DATA_W-1:0]  cop_data,
  input  logic               cop_err
);

  import pio_bridge_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] C_DEPTH    = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  logic                en_q, en_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                cop_valid_q, cop_valid_d;
  logic [INSTR_W-1:0]  cop_instr_q, cop_instr_d;
  logic                cop_mem_sel_q, cop_mem_sel_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic                full_q, full_d;

  logic                push_req;
  logic                push_acc;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic [INSTR_W:0]    fifo_rdata;
  logic                err_set;

  assign en_d     = hps_enable;
  assign push_req = hps_enable & ~en_q;
  assign fifo_pop = (state_q == IDLE) & ~fifo_empty;
  assign push_acc = push_req & (~fifo_full | fifo_pop);

  cmd_fifo #(
    .WIDTH (INSTR_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .push  (push_req),
    .wdata ({hps_mem_sel, hps_instruct}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Dispatch FSM, timeout counter, result capture and flag next-state
  always_comb begin
    state_d       = state_q;
    cop_valid_d   = cop_valid_q;
    cop_instr_d   = cop_instr_q;
    cop_mem_sel_d = cop_mem_sel_q;
    tmo_d         = tmo_q;
    data_d        = data_q;
    done_d        = done_q;
    err_set       = 1'b0;

    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          cop_instr_d   = fifo_rdata[INSTR_W-1:0];
          cop_mem_sel_d = fifo_rdata[INSTR_W];
          cop_valid_d   = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (cop_valid_q && cop_ready) begin
          cop_valid_d = 1'b0;
          tmo_d       = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        tmo_d = tmo_q + TW'(1);
        // Completion on the last timeout cycle still counts as completion
        if (cop_done) begin
          data_d  = cop_data;
          done_d  = 1'b1;
          err_set = cop_err;
          state_d = IDLE;
        end else if (tmo_q == C_TMO_LAST) begin
          err_set = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Dropped push raises the overflow error; an accepted push clears done
    if (push_req && !push_acc) err_set = 1'b1;
    if (push_acc) done_d = 1'b0;

    // Set beats clear when both happen in the same cycle
    err_d  = (err_q & ~hps_clr_err) | err_set;
    busy_d = (state_q != IDLE) | (fifo_count != '0);
    full_d = (fifo_count == C_DEPTH);
  end

  // State and registered outputs
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q       <= IDLE;
      en_q          <= 1'b0;
      tmo_q         <= '0;
      cop_valid_q   <= 1'b0;
      cop_instr_q   <= '0;
      cop_mem_sel_q <= 1'b0;
      data_q        <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      full_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      tmo_q         <= tmo_d;
      cop_valid_q   <= cop_valid_d;
      cop_instr_q   <= cop_instr_d;
      cop_mem_sel_q <= cop_mem_sel_d;
      data_q        <= data_d;
      done_q        <= done_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      full_q        <= full_d;
    end
  end

  assign hps_flags[FLG_DONE] = done_q;
  assign hps_flags[FLG_BUSY] = busy_q;
  assign hps_flags[FLG_ERR]  = err_q;
  assign hps_flags[FLG_FULL] = full_q;
  assign hps_data_out        = data_q;
  assign cop_valid           = cop_valid_q;
  assign cop_instr           = cop_instr_q;
  assign cop_mem_sel         = cop_mem_sel_q;

endmodule : pio_cmd_bridge
`default_nettype wire

// File: tb/tb_pio_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_cmd_bridge
// Description : Self-checking bench for pio_cmd_bridge. A transaction-level
//               model tracks the command queue, bridge ownership and flags;
//               a scoreboard queue holds expected dispatched commands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_cmd_bridge;

  import pio_bridge_pkg::*;

  localparam int INSTR_W     = 29;
  localparam int DATA_W      = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 16;

  // Abstract bridge ownership phases
  localparam int PH_IDLE  = 0;
  localparam int PH_OFFER = 1;
  localparam int PH_EXEC  = 2;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_reset_n;
  logic               hps_enable;
  logic [INSTR_W-1:0] hps_instruct;
  logic               hps_mem_sel;
  logic               hps_clr_err;
  logic [3:0]         hps_flags;
  logic [DATA_W-1:0]  hps_data_out;
  logic               cop_valid;
  logic               cop_ready;
  logic [INSTR_W-1:0] cop_instr;
  logic               cop_mem_sel;
  logic               cop_done;
  logic [DATA_W-1:0]  cop_data;
  logic               cop_err;

  pio_cmd_bridge #(
    .INSTR_W     (INSTR_W),
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (reset_reset_n),
    .hps_enable    (hps_enable),
    .hps_instruct  (hps_instruct),
    .hps_mem_sel   (hps_mem_sel),
    .hps_clr_err   (hps_clr_err),
    .hps_flags     (hps_flags),
    .hps_data_out  (hps_data_out),
    .cop_valid     (cop_valid),
    .cop_ready     (cop_ready),
    .cop_instr     (cop_instr),
    .cop_mem_sel   (cop_mem_sel),
    .cop_done      (cop_done),
    .cop_data      (cop_data),
    .cop_err       (cop_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Coprocessor agent knobs
  int rdy_pct, dly_min, dly_max, err_pct, fixed_data;
  bit spur_en;
  bit mon_en;
  bit a_wait;
  int a_cnt, a_dly;

  // Reference model state
  logic [INSTR_W:0]  m_q[$];
  logic [INSTR_W:0]  exp_cmd[$];
  int                m_ph, m_tmo, m_sz;
  bit                m_en_prev, m_done, m_err, m_busy, m_full;
  bit                m_pop, m_preq, m_acc, m_eset, m_nbusy, m_nfull;
  logic [DATA_W-1:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [INSTR_W-1:0] instr, input logic ms);
    hps_instruct = instr;
    hps_mem_sel  = ms;
    hps_enable   = 1'b1;
    cyc();
    hps_enable   = 1'b0;
    cyc();
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      cyc();
      if (hps_flags[FLG_BUSY] == 1'b0 && m_ph == PH_IDLE && m_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: bridge still busy after 500 cycles (flags=0x%0h)", name, hps_flags);
  endtask

  // Reference model: applies the bridge rules once per clock edge
  always @(posedge clk) begin
    if (!reset_reset_n) begin
      m_q.delete();
      exp_cmd.delete();
      m_ph = PH_IDLE; m_tmo = 0; m_en_prev = 1'b0;
      m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_full = 1'b0; m_data = '0;
    end else begin
      m_sz    = m_q.size();
      m_pop   = (m_ph == PH_IDLE) && (m_sz > 0);
      m_preq  = hps_enable && !m_en_prev;
      m_acc   = m_preq && ((m_sz < FIFO_DEPTH) || m_pop);
      m_eset  = m_preq && !m_acc;
      m_nbusy = (m_ph != PH_IDLE) || (m_sz != 0);
      m_nfull = (m_sz == FIFO_DEPTH);
      case (m_ph)
        PH_IDLE: if (m_pop) begin void'(m_q.pop_front()); m_ph = PH_OFFER; end
        PH_OFFER: if (cop_ready) begin m_ph = PH_EXEC; m_tmo = 0; end
        default: begin
          if (cop_done) begin
            m_data = cop_data; m_done = 1'b1;
            if (cop_err) m_eset = 1'b1;
            m_ph = PH_IDLE;
          end else if (m_tmo == TIMEOUT_CYC - 1) begin
            m_eset = 1'b1; m_ph = PH_IDLE;
          end else m_tmo++;
        end
      endcase
      if (m_acc) begin
        m_q.push_back({hps_mem_sel, hps_instruct});
        exp_cmd.push_back({hps_mem_sel, hps_instruct});
        m_done = 1'b0;
      end
      m_err     = (m_err && !hps_clr_err) || m_eset;
      m_en_prev = hps_enable;
      m_busy    = m_nbusy;
      m_full    = m_nfull;
    end
  end

  // Monitor: compares outputs against the model and pops the command scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      chk("flags", 32'(hps_flags), 32'({m_full, m_err, m_busy, m_done}));
      chk("data_out", 32'(hps_data_out), 32'(m_data));
      chk("cop_valid", 32'(cop_valid), 32'(m_ph == PH_OFFER));
      if (cop_valid) begin
        if (exp_cmd.size() == 0) begin
          n_checks++;
          $display("FAIL cop_cmd: actual=0x%0h expected=<none queued>", {cop_mem_sel, cop_instr});
        end else begin
          chk("cop_cmd", 32'({cop_mem_sel, cop_instr}), 32'(exp_cmd[0]));
          if (cop_ready) void'(exp_cmd.pop_front());
        end
      end
    end
  end

  // Coprocessor agent: ready, delayed completion, optional spurious pulses
  always @(posedge clk) begin
    #2;
    cop_done = 1'b0;
    if (!reset_reset_n) begin
      a_wait    = 1'b0;
      cop_ready = 1'b0;
    end else begin
      if (a_wait) begin
        if (a_cnt <= 1) begin
          cop_done = 1'b1;
          cop_data = (fixed_data < 0) ? DATA_W'($urandom) : DATA_W'(fixed_data);
          cop_err  = (int'($urandom_range(0, 99)) < err_pct);
          a_wait   = 1'b0;
        end else a_cnt--;
      end else if (spur_en && $urandom_range(0, 15) == 0) begin
        cop_done = 1'b1;
        cop_data = DATA_W'($urandom);
        cop_err  = 1'($urandom_range(0, 1));
      end
      cop_ready = (int'($urandom_range(0, 99)) < rdy_pct);
      if (cop_valid && cop_ready && !a_wait) begin
        a_dly = int'($urandom_range(dly_min, dly_max));
        // Delays beyond the timeout window never answer
        if (a_dly <= TIMEOUT_CYC) begin
          a_wait = 1'b1;
          a_cnt  = a_dly;
        end
      end
    end
  end

  // Stimulus
  initial begin
    reset_reset_n = 1'b0; hps_enable = 1'b0; hps_instruct = '0; hps_mem_sel = 1'b0;
    hps_clr_err = 1'b0; cop_ready = 1'b0; cop_done = 1'b0; cop_data = '0; cop_err = 1'b0;
    rdy_pct = 100; dly_min = 5; dly_max = 5; err_pct = 0; fixed_data = 8'hA5;
    spur_en = 1'b0; mon_en = 1'b0; a_wait = 1'b0; a_cnt = 0;
    repeat (3) cyc();
    chk("reset_flags", 32'(hps_flags), 32'h0);
    chk("reset_valid", 32'(cop_valid), 32'h0);
    reset_reset_n = 1'b1;
    mon_en = 1'b1;

    // Single command
    pulse(29'h0000123, 1'b0);
    wait_idle("single_idle");
    chk("single_data", 32'(hps_data_out), 32'hA5);
    chk("single_flags", 32'(hps_flags), 32'b0001);

    // Enable held high yields one push only
    fixed_data = -1; dly_min = 2; dly_max = 2;
    hps_instruct = 29'h000003C; hps_enable = 1'b1;
    repeat (5) cyc();
    hps_enable = 1'b0;
    wait_idle("hold_idle");

    // Backpressure
    rdy_pct = 0;
    pulse(29'h0ABCDEF, 1'b1);
    repeat (10) cyc();
    chk("bp_valid", 32'(cop_valid), 32'h1);
    chk("bp_busy", 32'(hps_flags[FLG_BUSY]), 32'h1);
    rdy_pct = 100;
    wait_idle("bp_idle");

    // Overflow
    rdy_pct = 0;
    for (int i = 0; i < 6; i++) pulse(INSTR_W'(32'h100 + i), i[0]);
    chk("ovf_full", 32'(hps_flags[FLG_FULL]), 32'h1);
    chk("ovf_err", 32'(hps_flags[FLG_ERR]), 32'h1);
    hps_clr_err = 1'b1;
    cyc();
    hps_clr_err = 1'b0;
    chk("ovf_clr", 32'(hps_flags[FLG_ERR]), 32'h0);
    rdy_pct = 100; dly_min = 3; dly_max = 3;
    wait_idle("ovf_idle");

    // Timeout
    dly_min = 20; dly_max = 20;
    pulse(29'h0000055, 1'b0);
    wait_idle("tmo_idle");
    chk("tmo_err", 32'(hps_flags[FLG_ERR]), 32'h1);
    hps_clr_err = 1'b1;
    cyc();
    hps_clr_err = 1'b0;

    // Ordering and pointer wrap
    dly_min = 1; dly_max = 1;
    for (int i = 1; i <= 10; i++) begin
      hps_instruct = INSTR_W'(i);
      hps_enable = 1'b1;
      cyc();
      hps_enable = 1'b0;
      repeat (3) cyc();
    end
    wait_idle("order_idle");
    chk("order_err", 32'(hps_flags[FLG_ERR]), 32'h0);

    // Reset in the middle of WAIT
    dly_min = 12; dly_max = 12;
    pulse(29'h0000077, 1'b1);
    repeat (4) cyc();
    reset_reset_n = 1'b0;
    cyc();
    reset_reset_n = 1'b1;
    chk("rst_flags", 32'(hps_flags), 32'h0);
    chk("rst_data", 32'(hps_data_out), 32'h0);
    chk("rst_valid", 32'(cop_valid), 32'h0);
    dly_min = 4; dly_max = 4; fixed_data = 8'h3C;
    pulse(29'h0000078, 1'b0);
    wait_idle("rst_after_idle");
    chk("rst_after_data", 32'(hps_data_out), 32'h3C);
    chk("rst_after_flags", 32'(hps_flags), 32'b0001);

    // Randomized traffic
    rdy_pct = 70; dly_min = 1; dly_max = 20; err_pct = 15; spur_en = 1'b1; fixed_data = -1;
    repeat (400) begin
      hps_enable   = 1'($urandom_range(0, 1));
      hps_instruct = INSTR_W'($urandom);
      hps_mem_sel  = 1'($urandom_range(0, 1));
      hps_clr_err  = ($urandom_range(0, 19) == 0);
      cyc();
    end
    hps_enable = 1'b0; hps_clr_err = 1'b0; spur_en = 1'b0;
    wait_idle("rand_idle");
    repeat (2) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pio_cmd_bridge
`default_nettype wire
